// File: rtl/config_loader_pkg.sv
// Shared types and constants for the fabric self-configuration byte loader.
package config_loader_pkg;

    localparam int CFG_WORD_W = 32;
    localparam int CFG_BYTE_W = 8;

    localparam logic [CFG_WORD_W-1:0] DEFAULT_SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [CFG_WORD_W-1:0] DEFAULT_DESYNC_WORD = 32'hFAB0_FAB0;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/cfg_idle_timer.sv
// Session idle counter: expired pulses combinationally on the idle cycle that brings the count to TIMEOUT_CYCLES.
// No flow control; clr and expiry both return the count to zero on the same edge.
module cfg_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Firing on the increment that would land on TIMEOUT_CYCLES lets the abort happen on that very edge.
    assign expired = en && (cnt == LAST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || expired) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/config_word_assembler.sv
// Hunts a sync word in a byte stream and packs following bytes MSB-first into 32-bit words; strobe one cycle after the 4th byte.
// Never backpressures (byte_ready = ~reset); optional trailing checksum word enabled by CONFIG_CHECKSUM_EN.
module config_word_assembler
    import config_loader_pkg::*;
#(
    parameter logic [CFG_WORD_W-1:0] SYNC_WORD      = DEFAULT_SYNC_WORD,
    parameter logic [CFG_WORD_W-1:0] DESYNC_WORD    = DEFAULT_DESYNC_WORD,
    parameter int                    TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [CFG_BYTE_W-1:0] byte_data,
    output logic                  byte_ready,
    output logic                  SelfWriteStrobe,
    output logic [CFG_WORD_W-1:0] SelfWriteData,
    output logic                  ComActive,
    output logic [15:0]           word_count,
    output logic                  timeout_flag,
    output logic                  check_error
);

    cfg_state_t            state, state_nxt;
    logic [CFG_WORD_W-1:0] sr, sr_nxt;
    logic [CFG_WORD_W-1:0] shifted;
    logic [1:0]            idx, idx_nxt;
    logic                  strobe_nxt;
    logic [CFG_WORD_W-1:0] wdata_nxt;
    logic [15:0]           wcnt_nxt;
    logic                  tflag_nxt;
    logic                  accept;
    logic                  idle_en;
    logic                  idle_clr;
    logic                  expired;

`ifdef CONFIG_CHECKSUM_EN
    logic [CFG_WORD_W-1:0] csum, csum_nxt;
    logic                  cerr_nxt;
`endif

    assign byte_ready = ~reset;
    assign accept     = byte_valid & byte_ready;
    assign shifted    = {sr[CFG_WORD_W-CFG_BYTE_W-1:0], byte_data};
    assign ComActive  = (state != HUNT);
    assign idle_en    = (state != HUNT) && !accept;
    assign idle_clr   = (state == HUNT) || accept;

    cfg_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (CLK),
        .rst    (reset),
        .clr    (idle_clr),
        .en     (idle_en),
        .expired(expired)
    );

    always_comb begin
        state_nxt  = state;
        sr_nxt     = sr;
        idx_nxt    = idx;
        strobe_nxt = 1'b0;
        wdata_nxt  = SelfWriteData;
        wcnt_nxt   = word_count;
        tflag_nxt  = timeout_flag;
`ifdef CONFIG_CHECKSUM_EN
        csum_nxt   = csum;
        cerr_nxt   = check_error;
`endif
        if (expired) begin
            state_nxt = HUNT;
            sr_nxt    = '0;
            idx_nxt   = '0;
            tflag_nxt = 1'b1;
        end else if (accept) begin
            sr_nxt = shifted;
            case (state)
                HUNT: begin
                    if (shifted == SYNC_WORD) begin
                        state_nxt = LOAD;
                        idx_nxt   = '0;
                        wcnt_nxt  = '0;
                        tflag_nxt = 1'b0;
`ifdef CONFIG_CHECKSUM_EN
                        csum_nxt  = '0;
                        cerr_nxt  = 1'b0;
`endif
                    end
                end
                LOAD: begin
                    idx_nxt = idx + 2'd1;
                    if (idx == 2'd3) begin
                        if (shifted == DESYNC_WORD) begin
                            sr_nxt = '0;
`ifdef CONFIG_CHECKSUM_EN
                            state_nxt = CHECK;
`else
                            state_nxt = HUNT;
`endif
                        end else begin
                            strobe_nxt = 1'b1;
                            wdata_nxt  = shifted;
                            wcnt_nxt   = word_count + 16'd1;
`ifdef CONFIG_CHECKSUM_EN
                            csum_nxt   = csum + shifted;
`endif
                        end
                    end
                end
`ifdef CONFIG_CHECKSUM_EN
                CHECK: begin
                    idx_nxt = idx + 2'd1;
                    if (idx == 2'd3) begin
                        if (shifted != csum) begin
                            cerr_nxt = 1'b1;
                        end
                        state_nxt = HUNT;
                        sr_nxt    = '0;
                    end
                end
`endif
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state           <= HUNT;
            sr              <= '0;
            idx             <= '0;
            SelfWriteStrobe <= 1'b0;
            SelfWriteData   <= '0;
            word_count      <= '0;
            timeout_flag    <= 1'b0;
        end else begin
            state           <= state_nxt;
            sr              <= sr_nxt;
            idx             <= idx_nxt;
            SelfWriteStrobe <= strobe_nxt;
            SelfWriteData   <= wdata_nxt;
            word_count      <= wcnt_nxt;
            timeout_flag    <= tflag_nxt;
        end
    end

`ifdef CONFIG_CHECKSUM_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            csum        <= '0;
            check_error <= 1'b0;
        end else begin
            csum        <= csum_nxt;
            check_error <= cerr_nxt;
        end
    end
`else
    assign check_error = 1'b0;
`endif

endmodule

// File: tb/tb_config_word_assembler.sv
// Directed bench for config_word_assembler with a short idle timeout.
module tb_config_word_assembler;

    logic        CLK = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        SelfWriteStrobe;
    logic [31:0] SelfWriteData;
    logic        ComActive;
    logic [15:0] word_count;
    logic        timeout_flag;
    logic        check_error;

    int vectors = 0;
    int errors  = 0;
    int strobes = 0;
    int s0;

    always #5 CLK = ~CLK;

    config_word_assembler #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .SelfWriteStrobe(SelfWriteStrobe),
        .SelfWriteData  (SelfWriteData),
        .ComActive      (ComActive),
        .word_count     (word_count),
        .timeout_flag   (timeout_flag),
        .check_error    (check_error)
    );

    always @(negedge CLK) begin
        if (SelfWriteStrobe === 1'b1) strobes++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge CLK);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        idle(2);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_strobe", 32'(SelfWriteStrobe), 32'd0);
        chk("rst_data", SelfWriteData, 32'd0);
        chk("rst_active", 32'(ComActive), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_tflag", 32'(timeout_flag), 32'd0);
        chk("rst_cerr", 32'(check_error), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(byte_ready), 32'd1);
        idle(1);

        // Basic session: sync, one word, desync
        s0 = strobes;
        send_word(32'hFAB0_FAB1);
        chk("t1_active_on", 32'(ComActive), 32'd1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        chk("t1_no_early_strobe", 32'(SelfWriteStrobe), 32'd0);
        send_byte(8'h78);
        chk("t1_strobe", 32'(SelfWriteStrobe), 32'd1);
        chk("t1_data", SelfWriteData, 32'h1234_5678);
        chk("t1_count", 32'(word_count), 32'd1);
        idle(1);
        chk("t1_strobe_1cyc", 32'(SelfWriteStrobe), 32'd0);
        chk("t1_data_hold", SelfWriteData, 32'h1234_5678);
        send_word(32'hFAB0_FAB0);
        chk("t1_active_off", 32'(ComActive), 32'd0);
        chk("t1_strobes", 32'(strobes - s0), 32'd1);
        chk("t1_count_kept", 32'(word_count), 32'd1);

        // Misaligned sync hunt
        s0 = strobes;
        send_byte(8'h00); send_byte(8'hFA);
        send_word(32'hFAB0_FAB1);
        chk("t2_active", 32'(ComActive), 32'd1);
        chk("t2_count_clr", 32'(word_count), 32'd0);
        send_word(32'hDEAD_BEEF);
        chk("t2_strobe", 32'(SelfWriteStrobe), 32'd1);
        chk("t2_data", SelfWriteData, 32'hDEAD_BEEF);
        send_word(32'hFAB0_FAB0);
        chk("t2_active_off", 32'(ComActive), 32'd0);
        chk("t2_strobes", 32'(strobes - s0), 32'd1);

        // Sync word inside a session is data; then timeout boundary
        s0 = strobes;
        send_word(32'hFAB0_FAB1);
        send_word(32'hFAB0_FAB1);
        chk("t4_sync_data", SelfWriteData, 32'hFAB0_FAB1);
        chk("t4_sync_strobe", 32'(SelfWriteStrobe), 32'd1);
        send_word(32'h0102_0304);
        chk("t4_data2", SelfWriteData, 32'h0102_0304);
        chk("t4_count", 32'(word_count), 32'd2);
        idle(15);
        send_byte(8'h11);
        chk("t4_byte_beats_timeout", 32'(ComActive), 32'd1);
        idle(15);
        chk("t4_active_before_to", 32'(ComActive), 32'd1);
        idle(1);
        chk("t4_timeout_active", 32'(ComActive), 32'd0);
        chk("t4_timeout_flag", 32'(timeout_flag), 32'd1);
        chk("t4_count_kept", 32'(word_count), 32'd2);
        chk("t4_strobes", 32'(strobes - s0), 32'd2);

        // Timeout mid-word with gap, flag cleared by fresh sync
        s0 = strobes;
        send_word(32'hFAB0_FAB1);
        chk("t3_sync_clr_flag", 32'(timeout_flag), 32'd0);
        send_byte(8'hAA);
        idle(16);
        send_byte(8'hBB);
        chk("t3_tflag", 32'(timeout_flag), 32'd1);
        chk("t3_active", 32'(ComActive), 32'd0);
        chk("t3_strobes", 32'(strobes - s0), 32'd0);
        send_word(32'hFAB0_FAB1);
        chk("t3_resync_clr", 32'(timeout_flag), 32'd0);
        send_word(32'hFAB0_FAB0);

        // Checksum session(s)
        s0 = strobes;
        send_word(32'hFAB0_FAB1);
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        send_word(32'hFAB0_FAB0);
`ifdef CONFIG_CHECKSUM_EN
        chk("ck_in_check", 32'(ComActive), 32'd1);
        send_word(32'h0000_0003);
        chk("ck_good_active", 32'(ComActive), 32'd0);
        chk("ck_good_cerr", 32'(check_error), 32'd0);
        send_word(32'hFAB0_FAB1);
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        send_word(32'hFAB0_FAB0);
        send_word(32'h0000_0004);
        chk("ck_bad_cerr", 32'(check_error), 32'd1);
        chk("ck_bad_active", 32'(ComActive), 32'd0);
        send_word(32'hFAB0_FAB1);
        chk("ck_sync_clr", 32'(check_error), 32'd0);
        send_word(32'hFAB0_FAB0);
        send_word(32'h0000_0000);
        chk("ck_empty_cerr", 32'(check_error), 32'd0);
        chk("ck_strobes", 32'(strobes - s0), 32'd4);
`else
        chk("ck_off_active", 32'(ComActive), 32'd0);
        chk("ck_off_cerr", 32'(check_error), 32'd0);
        chk("ck_off_count", 32'(word_count), 32'd2);
        chk("ck_off_strobes", 32'(strobes - s0), 32'd2);
`endif

        // Reset cancels a strobe in flight
        send_word(32'hFAB0_FAB1);
        send_word(32'h0102_0304);
        send_word(32'h0506_0708);
        chk("r_strobe_pre", 32'(SelfWriteStrobe), 32'd1);
        reset = 1'b1;
        #1;
        chk("r_strobe_cancel", 32'(SelfWriteStrobe), 32'd0);
        chk("r_data", SelfWriteData, 32'd0);
        chk("r_count", 32'(word_count), 32'd0);
        chk("r_active", 32'(ComActive), 32'd0);
        chk("r_ready", 32'(byte_ready), 32'd0);
        idle(1);
        reset = 1'b0;
        idle(1);

        // Reset after 2 bytes of a word, then no sync => no strobe
        send_word(32'hFAB0_FAB1);
        send_byte(8'h01); send_byte(8'h02);
        reset = 1'b1;
        #1;
        chk("r2_active", 32'(ComActive), 32'd0);
        chk("r2_count", 32'(word_count), 32'd0);
        idle(1);
        reset = 1'b0;
        idle(1);
        s0 = strobes;
        send_word(32'h0304_0506);
        idle(2);
        chk("r2_no_strobe", 32'(strobes - s0), 32'd0);
        chk("r2_hunt", 32'(ComActive), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/config_word_assembler.md
# config_word_assembler

Byte-to-word front end for the fabric self-configuration path. It sits directly upstream of the fabric top's `SelfWriteStrobe`/`SelfWriteData` inputs. It accepts a byte stream from a host transport (UART receiver, SPI slave or SoC bridge), hunts for a sync word, and packs the following bytes MSB-first into 32-bit configuration words. Each word is presented with a single-cycle strobe until a desync word or an inactivity timeout ends the session.

## Interface
- `SYNC_WORD`, 32'hFAB0_FAB1, session start pattern; matched byte-aligned, not forwarded.
- `DESYNC_WORD`, 32'hFAB0_FAB0, session end pattern; matched word-aligned, not forwarded.
- `TIMEOUT_CYCLES`, 1_000_000, idle cycles in a session before abort; minimum 2.
- `CLK`  input  1  single clock.
- `reset`  input  1  reset, asynchronous and active-high.
- `byte_valid`  input  1  `byte_data` is valid this cycle.
- `byte_data`  input  8  incoming byte.
- `byte_ready`  output  1  byte accepted when `byte_valid && byte_ready`; constant 1 after reset release.
- `SelfWriteStrobe`  output  1  one-cycle pulse; `SelfWriteData` is valid this cycle.
- `SelfWriteData`  output  32  assembled configuration word; holds its last value between strobes.
- `ComActive`  output  1  high while a session is open (state ≠ HUNT).
- `word_count`  output  16  number of words forwarded in the current or last session; wraps at 2^16.
- `timeout_flag`  output  1  sticky; set when a session aborts on timeout; cleared by the next sync match.
- `check_error`  output  1  sticky checksum mismatch; see Configuration.

## Operation
- **Reset values:** state HUNT, shift register 0, byte index 0, `SelfWriteStrobe` 0, `SelfWriteData` 0, `ComActive` 0, `word_count` 0, `timeout_flag` 0, `check_error` 0, idle counter 0. `byte_ready` is 0 while `reset` is high and 1 otherwise.
- **HUNT:**
  - Every accepted byte shifts into the 32-bit register: `{sr[23:0], byte}`.
  - If the new register value equals `SYNC_WORD`, go to LOAD. On that transition: byte index ← 0, `word_count` ← 0, `timeout_flag` ← 0, `check_error` ← 0, checksum ← 0.
  - No strobes are generated in HUNT.
- **LOAD:**
  - Accepted bytes fill the word MSB-first; the byte index counts 0..3.
  - On the 4th byte, the completed word `w` is handled as follows:
    - If `w == DESYNC_WORD`: go to CHECK when `CONFIG_CHECKSUM_EN` is defined, otherwise go to HUNT. Clear the shift register. No strobe.
    - Otherwise: `SelfWriteData` ← `w`, `SelfWriteStrobe` ← 1 for exactly one cycle, `word_count` += 1, checksum += `w` (mod 2^32).
  - `SYNC_WORD` appearing inside LOAD is ordinary data and is forwarded.
- **Timeout:**
  - The idle counter increments on every cycle in LOAD or CHECK without an accepted byte, and clears on any accepted byte.
  - When it reaches `TIMEOUT_CYCLES`: go to HUNT, discard the partial word, set `timeout_flag`, and clear the shift register and idle counter. No strobe.
- **Simultaneous events:** a byte accepted in the same cycle the counter reaches `TIMEOUT_CYCLES` wins; the byte is processed and the counter clears.
- **Reset mid-session:** asynchronous return to reset values, including any partial word. A strobe in flight is cancelled.

## Timing
- Latency: the 4th byte is accepted on edge N; `SelfWriteStrobe`/`SelfWriteData` are registered and high during cycle N+1.
- Peak rate is one word per 4 cycles, so strobes are never back-to-back.
- `ComActive` rises the cycle after the sync word's last byte is accepted. It falls the cycle after the desync word completes (no checksum), after the checksum word completes, or after a timeout.
- There is no backpressure. Bytes are never dropped while out of reset.

## Configuration
- Macro: `CONFIG_CHECKSUM_EN`.
- **Defined:**
  - After the desync word, state CHECK collects 4 more bytes MSB-first (not forwarded).
  - If that word ≠ the running sum of the words forwarded this session, set `check_error`.
  - Then go to HUNT.
  - Timeout applies in CHECK.
- **Undefined:**
  - No CHECK state and no checksum register.
  - `check_error` is tied to 0.
  - Desync returns directly to HUNT.

## Structure
- Shared package `config_loader_pkg`:
  - State enum (HUNT, LOAD, CHECK).
  - Default `SYNC_WORD`/`DESYNC_WORD` constants.
  - `CFG_WORD_W` = 32 and `CFG_BYTE_W` = 8.
- One sub-module, `cfg_idle_timer`: the idle counter with clear and enable inputs and a `expired` output, width `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- Bytes FA B0 FA B1, 12 34 56 78, FA B0 FA B0 → one strobe with `SelfWriteData`=32'h1234_5678 one cycle after byte 0x78; `word_count`=1; `ComActive` 1 then 0.
- Garbage 00 FA FA B0 FA B1 then DE AD BE EF → sync found despite misalignment; one strobe with 32'hDEAD_BEEF.
- Sync, then AA BB with a gap of `TIMEOUT_CYCLES` (set to 16) → no strobe, `timeout_flag`=1, `ComActive`=0; a fresh sync clears `timeout_flag`.
- Sync, then FA B0 FA B1 01 02 03 04 → two strobes: 32'hFAB0_FAB1 and 32'h0102_0304.
- `CONFIG_CHECKSUM_EN`: sync, words 0000_0001 and 0000_0002, desync, checksum 0000_0003 → `check_error`=0. Repeating with checksum 0000_0004 → `check_error`=1.
- Assert `reset` after 2 bytes of a word → all outputs at reset values; after release, the next 4 bytes without a sync word produce no strobe.
